// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Each byte is presented with a one-cycle readinterrupt pulse and parity/framing flags.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       data_in,
   output logic [7:0] out,
   output logic       readinterrupt,
   output logic       parity_error,
   output logic       framing_error,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic          ODD      = 1'(PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t        state;
   logic          sync1;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          par;
   logic          perr;
   logic          tick;

   assign tick = (cnt == '0);

   // NOTE: every register lives in one clocked block and uses <= so that all
   // reads see the pre-edge value; later assignments in the block take priority.
   always_ff @(posedge clk) begin
      if (clear) begin
         sync1         <= 1'b1;
         rx_s          <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         par           <= 1'b0;
         perr          <= 1'b0;
         out           <= '0;
         readinterrupt <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         sync1         <= data_in;
         rx_s          <= sync1;
         readinterrupt <= 1'b0;

         // Baud counter runs in every bit-timed state; IDLE overrides with its own load.
         if (state != IDLE && state != BREAK)
            cnt <= tick ? FULL_BIT : cnt - CW'(1);

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= HALF_BIT;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                     idx   <= '0;
                     par   <= 1'b0;
                     perr  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {rx_s, shreg[7:1]};
                  par   <= par ^ rx_s;
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7)
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (tick) begin
                  perr  <= (rx_s != (par ^ ODD));
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  out           <= shreg;
                  readinterrupt <= 1'b1;
                  parity_error  <= (PARITY_EN != 0) ? perr : 1'b0;
                  framing_error <= ~rx_s;
                  state         <= rx_s ? IDLE : BREAK;
                  busy          <= ~rx_s;
               end
            end
            BREAK: begin
               // A line held low after the frame must not look like a new start bit.
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed scenarios plus randomized frames on two
// instances (even parity, no parity), checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } pulse_t;

   logic clk = 1'b0;
   logic clear = 1'b1;
   logic line0 = 1'b1;
   logic line1 = 1'b1;
   logic [7:0] out0, out1;
   logic ri0, ri1, pe0, pe1, fe0, fe1, busy0, busy1;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   pulse_t q0[$];
   pulse_t q1[$];

   uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
      .clk(clk), .clear(clear), .data_in(line0), .out(out0), .readinterrupt(ri0),
      .parity_error(pe0), .framing_error(fe0), .busy(busy0));

   uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
      .clk(clk), .clear(clear), .data_in(line1), .out(out1), .readinterrupt(ri1),
      .parity_error(pe1), .framing_error(fe1), .busy(busy1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every readinterrupt cycle is logged, so a stretched pulse shows up as an extra entry.
   always @(negedge clk) begin
      if (ri0) q0.push_back('{cyc, out0, pe0, fe0});
      if (ri1) q1.push_back('{cyc, out1, pe1, fe1});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel == 1) line1 = v;
      else          line0 = v;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one whole frame, 16 clocks per bit; the line is left at the stop value.
   task automatic send_frame(input int sel, input logic [7:0] b, input logic pbit,
                             input logic stop, output int e0);
      logic [10:0] bits;
      int nb;
      if (sel == 0) begin
         bits = {stop, pbit, b, 1'b0};
         nb = 11;
      end else begin
         bits = {1'b0, stop, b, 1'b0};
         nb = 10;
      end
      e0 = cyc;
      for (int i = 0; i < nb; i++) begin
         drive(sel, bits[i]);
         cycles(16);
      end
   endtask

   // Frame-level reference: first low seen 3 edges after the line falls,
   // stop sampled half a bit plus (bits-1) whole bits later.
   function automatic int exp_cyc(input int sel, input int e0);
      int nb;
      nb = (sel == 0) ? 11 : 10;
      return e0 + 3 + 8 + 16 * (nb - 1);
   endfunction

   function automatic logic exp_pe(input int sel, input logic [7:0] b, input logic pbit);
      return (sel == 0) ? (pbit != ^b) : 1'b0;
   endfunction

   task automatic expect_pulse(input string tag, input int sel, input int ecyc,
                               input logic [7:0] b, input logic pe, input logic fe);
      pulse_t p;
      int n;
      n = (sel == 1) ? q1.size() : q0.size();
      check({tag, "_count"}, n, 1);
      if (n > 0) begin
         if (sel == 1) p = q1.pop_front();
         else          p = q0.pop_front();
         check({tag, "_cycle"}, p.cyc, ecyc);
         check({tag, "_out"}, {24'd0, p.d}, {24'd0, b});
         check({tag, "_perr"}, {31'd0, p.pe}, {31'd0, pe});
         check({tag, "_ferr"}, {31'd0, p.fe}, {31'd0, fe});
      end
      q0.delete();
      q1.delete();
   endtask

   initial begin
      int e0, e1;
      pulse_t pa, pb;
      logic [7:0] b;
      logic pbit, stop;
      int sel;

      cycles(3);
      clear = 1'b0;
      check("rst_out0", {24'd0, out0}, 32'd0);
      check("rst_ri0", {31'd0, ri0}, 32'd0);
      check("rst_pe0", {31'd0, pe0}, 32'd0);
      check("rst_fe0", {31'd0, fe0}, 32'd0);
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      check("rst_out1", {24'd0, out1}, 32'd0);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
      cycles(4);

      send_frame(0, 8'hA5, 1'b0, 1'b1, e0);
      expect_pulse("a5", 0, e0 + 171, 8'hA5, 1'b0, 1'b0);
      cycles(5);

      send_frame(0, 8'h01, 1'b0, 1'b1, e0);
      expect_pulse("bad_par", 0, exp_cyc(0, e0), 8'h01, 1'b1, 1'b0);
      cycles(5);
      send_frame(0, 8'h03, 1'b0, 1'b1, e0);
      expect_pulse("par_clr", 0, exp_cyc(0, e0), 8'h03, 1'b0, 1'b0);
      cycles(5);

      send_frame(0, 8'h5A, 1'b0, 1'b0, e0);
      cycles(40);
      check("brk_busy_low", {31'd0, busy0}, 32'd1);
      expect_pulse("brk", 0, exp_cyc(0, e0), 8'h5A, 1'b0, 1'b1);
      line0 = 1'b1;
      cycles(6);
      check("brk_busy_rel", {31'd0, busy0}, 32'd0);
      cycles(30);
      check("brk_no_more", q0.size(), 0);

      line0 = 1'b0;
      cycles(5);
      check("glitch_busy", {31'd0, busy0}, 32'd1);
      line0 = 1'b1;
      cycles(20);
      check("glitch_busy_end", {31'd0, busy0}, 32'd0);
      check("glitch_no_pulse", q0.size(), 0);
      check("glitch_out", {24'd0, out0}, 32'h5A);

      send_frame(1, 8'h55, 1'b0, 1'b1, e0);
      send_frame(1, 8'hAA, 1'b0, 1'b1, e1);
      check("b2b_count", q1.size(), 2);
      if (q1.size() == 2) begin
         pa = q1.pop_front();
         pb = q1.pop_front();
         check("b2b_first_cycle", pa.cyc, exp_cyc(1, e0));
         check("b2b_spacing", pb.cyc - pa.cyc, 160);
         check("b2b_first_out", {24'd0, pa.d}, 32'h55);
         check("b2b_second_out", {24'd0, pb.d}, 32'hAA);
      end
      q1.delete();
      cycles(5);

      // Abort during data bit 4 (bit slot 5), halfway through the bit.
      line0 = 1'b0;
      cycles(16);
      b = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         line0 = b[i];
         cycles(16);
      end
      line0 = b[4];
      cycles(8);
      clear = 1'b1;
      line0 = 1'b1;
      cycles(1);
      clear = 1'b0;
      check("clr_out", {24'd0, out0}, 32'd0);
      check("clr_ri", {31'd0, ri0}, 32'd0);
      check("clr_pe", {31'd0, pe0}, 32'd0);
      check("clr_fe", {31'd0, fe0}, 32'd0);
      check("clr_busy", {31'd0, busy0}, 32'd0);
      cycles(40);
      check("clr_no_pulse", q0.size(), 0);
      send_frame(0, 8'h3C, 1'b0, 1'b1, e0);
      expect_pulse("after_clr", 0, exp_cyc(0, e0), 8'h3C, 1'b0, 1'b0);
      cycles(3);

      for (int k = 0; k < 24; k++) begin
         sel  = int'($urandom_range(0, 1));
         b    = 8'($urandom);
         pbit = ($urandom_range(0, 2) == 0) ? ~(^b) : ^b;
         stop = ($urandom_range(0, 3) != 0);
         send_frame(sel, b, pbit, stop, e0);
         if (!stop) begin
            cycles(int'($urandom_range(0, 30)));
            drive(sel, 1'b1);
            cycles(4);
         end
         expect_pulse("rand", sel, exp_cyc(sel, e0), b, exp_pe(sel, b, pbit), ~stop);
         cycles(int'($urandom_range(0, 12)));
      end

      cycles(40);
      check("final_idle0", {31'd0, busy0}, 32'd0);
      check("final_idle1", {31'd0, busy1}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Oversampling UART receiver. Recovers standard asynchronous frames from a serial line: idle high, 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Sits beside the UART transmit path as the line-side receiver for frames produced by a standard transmitter.
- Presents each received byte with a one-cycle valid pulse plus parity and framing error flags.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and at least 4.
- PARITY_EN, 1, 1 = parity bit present between data and stop; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- data_in  input  1  asynchronous serial line, idle high.
- out  output  8  last received byte.
- readinterrupt  output  1  one-cycle pulse: new byte on out.
- parity_error  output  1  parity mismatch on last frame.
- framing_error  output  1  stop bit sampled 0 on last frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (clear=1 at a clk edge) sets:
  - out=0, readinterrupt=0, parity_error=0, framing_error=0, busy=0.
  - Synchronizer flops = 1, state=IDLE, counters=0.
  - Reset overrides everything and aborts any frame in progress. No partial byte is ever reported.
- data_in passes through a 2-flop synchronizer. All decisions use the second flop (rx_s).
- Baud counter width is clog2(CLKS_PER_BIT). Bit index is 3 bits.
- State IDLE:
  - busy=0.
  - When rx_s=0: go to START, load counter = CLKS_PER_BIT/2-1.
- Sampling rule (all states except IDLE and BREAK):
  - Counter decrements each cycle.
  - When counter=0, sample rx_s and reload counter = CLKS_PER_BIT-1.
  - Samples therefore fall at mid-bit.
- State START: at sample:
  - rx_s=0: go to DATA, bit index=0.
  - rx_s=1: glitch. Go to IDLE; no flags change.
- State DATA:
  - Each sample shifts rx_s into the MSB of the shift register (LSB-first reception).
  - The running parity XOR is updated.
  - After sample with bit index=7: go to PARITY if PARITY_EN, else STOP.
- State PARITY: at sample, compute expected = data XOR reduction XOR PARITY_ODD. Mismatch latches an internal perr. Go to STOP.
- State STOP: at sample:
  - On the next edge: out<=shift register, readinterrupt<=1 for exactly one cycle, parity_error<=perr (0 if PARITY_EN=0), framing_error<=~rx_s.
  - rx_s=1: go to IDLE.
  - rx_s=0: go to BREAK.
- State BREAK: wait until rx_s=1, then go to IDLE. Prevents a held-low line from re-triggering.
- busy=1 in START, DATA, PARITY, STOP, BREAK.
- out, parity_error and framing_error hold until the next completed frame or reset.
- Latency: rx_s low is first seen at edge d. Sample k (k=0 is start) occurs at edge d+CLKS_PER_BIT/2+k*CLKS_PER_BIT. readinterrupt is high for the cycle after the stop sample.
- Back-to-back frames: a new start bit arriving right after the stop sample is detected from IDLE. No dead cycles beyond one cycle.

Test Plan:
- Reset, CLKS_PER_BIT=16, even parity. Drive data_in low right after edge 0, then byte 0xA5, parity 0, stop 1, each held 16 cycles.
  -> rx_s low seen at edge 3.
  -> Stop sampled at edge 171.
  -> readinterrupt high only between edges 171 and 172; out=0xA5, parity_error=0, framing_error=0.
- Same framing, byte 0x01 with parity bit 0 (wrong for even parity) -> out=0x01, parity_error=1, framing_error=0. Then send 0x03 with parity 0 -> parity_error clears to 0.
- Stop bit driven 0, line held low for 40 more cycles -> framing_error=1, one readinterrupt only, busy stays 1 until line returns high, then busy=0 and no further pulses.
- Low glitch of 5 cycles on idle line -> START aborts at mid-bit sample. No readinterrupt, busy returns 0, out unchanged.
- Two back-to-back frames 0x55 then 0xAA with PARITY_EN=0 -> two readinterrupt pulses 160 cycles apart; out=0x55, then 0xAA.
- clear asserted during data bit 4 of a frame -> all outputs 0 the next cycle, no readinterrupt for that frame. The following clean frame 0x3C is received correctly.
